// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter sizing rule.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A 1- or 2-bit operand still needs a 1-bit counter; $clog2(1) would give 0.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin with borrow-out.
// This is the arithmetic cell that the serial datapath reuses for every bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first.
// Operands arrive and results leave over valid/ready handshakes.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;
  logic             w_release;

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds valid and data until then.
  assign in_ready    = (r_state == IDLE) && !rst;
  assign out_valid   = (r_state == DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
  assign o_dbg_state = r_state;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;
  assign w_last    = (r_cnt == LAST_CNT);

  full_subtractor u_full_subtractor (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_next)
  );

  // New difference bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_single
      assign w_res_next = w_d;
    end else begin : g_res_multi
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (w_release) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_res <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic [1:0]   o_dbg_state;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t         vecs[10];
  logic [W:0]   exp_q[$];
  int           n_pass;
  int           n_total;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .bout        (bout),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: present operands for one accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] ediff, input logic ebout);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    exp_q.push_back({ebout, ediff});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: count edges until out_valid and compare against the queue head.
  task automatic wait_result(input string name);
    int         lat;
    logic [W:0] exp;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (lat == 0) begin
        if (i > 1 || 1) begin
          @(posedge clk);
          #1;
          if (out_valid) lat = i;
        end
      end
    end
    check({name, "_latency"}, lat, W);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (lat != 0) begin
      check({name, "_diff"}, {24'd0, diff}, {24'd0, exp[W-1:0]});
      check({name, "_bout"}, {31'd0, bout}, {31'd0, exp[W]});
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hits;
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[6] = '{8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[8] = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
      wait_result($sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held, new operands ignored while out_ready is low
    send(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    wait_result("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a        = 8'hFF;
      b        = 8'h00;
      bin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_diff_held", {24'd0, diff}, 32'h23);
      check("bp_bout_held", {31'd0, bout}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake("bp");
    check("bp_state_idle", {30'd0, o_dbg_state}, 32'd0);
    send(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
    wait_result("bp_next");
    handshake("bp_next");

    // Reset four cycles into SHIFT aborts the operation
    send(8'h44, 8'h11, 1'b0, 8'h33, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid_in_rst", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    hits = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    check("abort_no_result", hits, 0);
    send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    wait_result("post_abort");
    handshake("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
